mips_pipe_reg: RTL and testbench

Parametrised elastic pipeline register for the 16-bit MIPS core, the successor to the fixed IF_ID / ID_EX latches. It carries one stage's bundle (instruction, PC+2, control bits, packed by the instantiating stage into `DATA_W` bits) across a valid/ready handshake. It adds a two-entry skid buffer, synchronous flush for branch squash, NOP-bubble output and a saturating stall counter. One instance sits between each pair of adjacent pipeline stages.

---
 rtl/mips_pipe_pkg.sv | 29 ++
 rtl/mips_pipe_reg_sat_counter.sv | 24 ++
 rtl/mips_pipe_reg.sv | 104 ++++++++++
 tb/tb_mips_pipe_reg.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline registers:
// handshake state encoding, default bubble value and stage bundle layouts.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // All-zero word decodes as a no-op in the 16-bit ISA
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    localparam int IFID_INSTR_LSB = 0;
    localparam int IFID_PC2_LSB   = 16;
    localparam int IFID_W         = 32;

    localparam int IDEX_CTRL_LSB  = 0;
    localparam int IDEX_CTRL_W    = 8;
    localparam int IDEX_IMM_LSB   = 8;
    localparam int IDEX_PC2_LSB   = 24;
    localparam int IDEX_W         = 40;

    function automatic logic [IFID_W-1:0] pack_if_id(input logic [15:0] instr,
                                                     input logic [15:0] pc_plus2);
        return {pc_plus2, instr};
    endfunction

endpackage

// File: rtl/mips_pipe_reg_sat_counter.sv
// Saturating event counter with synchronous clear; shared by the
// pipeline performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear wins over increment; the counter parks at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_pipe_reg.sv
// Elastic pipeline register between adjacent MIPS stages: two-entry skid
// buffer with flush, NOP bubbles on the output and a stall counter.
module mips_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Ready and valid are registered alongside the state so neither output
    // has a combinational path back from the handshake inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        main_q      <= in_data;
                        state       <= BUSY;
                        out_valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && !out_fire) begin
                        skid_q     <= in_data;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (in_fire) begin
                        main_q <= in_data;
                    end else if (out_fire) begin
                        main_q      <= NOP_VALUE;
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state      <= BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    main_q      <= NOP_VALUE;
                    skid_q      <= NOP_VALUE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (out_valid_q & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_mips_pipe_reg.sv
// Directed bench for mips_pipe_reg: expected beats are queued as stimulus is
// issued and a negedge monitor pops them on every downstream transfer.
module tb_mips_pipe_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;

    int                tests;
    int                fails;
    logic              mon_en;
    logic [DATA_W-1:0] exp_q[$];

    mips_pipe_reg #(
        .DATA_W    (DATA_W),
        .NOP_VALUE ({DATA_W{1'b0}}),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic ordy, input logic fl, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every downstream transfer must match the oldest outstanding beat
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_beat: got %h, expected none", out_data);
                end else begin
                    checkOutput("beat_data", out_data, exp_q.pop_front());
                end
            end else if (!out_valid) begin
                checkOutput("bubble_nop", out_data, 32'h0);
            end
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        applyStimulus(1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0);

        // reset held three cycles with an upstream beat offered
        repeat (3) step();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("rst_release_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        // streaming with one-cycle latency per beat
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h3);
        applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            checkOutput("stream_valid", 32'(out_valid), 32'd1);
            checkOutput("stream_data", out_data, 32'(i));
            if (i < 3) in_data = 32'(i + 1);
            else       in_valid = 1'b0;
        end
        step();
        checkOutput("stream_drained", 32'(out_valid), 32'd0);
        checkOutput("stream_stall_cnt", 32'(stall_cnt), 32'd0);

        // backpressure fills the skid entry and holds the third beat upstream
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h12);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step();
        in_data = 32'h11;
        step();
        in_data = 32'h12;
        checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_head_data", out_data, 32'h10);
        checkOutput("bp_cnt_first", 32'(stall_cnt), 32'd1);
        step();
        step();
        checkOutput("bp_held_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_cnt_stalled", 32'(stall_cnt), 32'd3);
        out_ready = 1'b1;
        step();
        checkOutput("bp_skid_to_main", out_data, 32'h11);
        checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        checkOutput("bp_last_data", out_data, 32'h12);
        in_valid = 1'b0;
        step();
        checkOutput("bp_drained", 32'(out_valid), 32'd0);
        checkOutput("bp_cnt_final", 32'(stall_cnt), 32'd3);

        // flush while FULL discards both held beats; counter keeps counting
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h21);
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
        step();
        cnt_clr = 1'b0;
        in_data = 32'h21;
        step();
        checkOutput("fl_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        exp_q.delete();
        flush = 1'b0;
        checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
        checkOutput("fl_out_data", out_data, 32'h0);
        checkOutput("fl_in_ready", 32'(in_ready), 32'd1);
        checkOutput("fl_stall_cnt", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1;
        repeat (3) step();
        checkOutput("fl_nothing_left", 32'(out_valid), 32'd0);

        // flush coincident with an accepted beat drops that beat
        exp_q.push_back(32'h2F);
        applyStimulus(1'b1, 32'h2F, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h30, 1'b1, 1'b1, 1'b0);
        step();
        exp_q.delete();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flin_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flin_out_data", out_data, 32'h0);
        checkOutput("flin_in_ready", 32'(in_ready), 32'd1);
        repeat (3) step();
        checkOutput("flin_dropped", 32'(out_valid), 32'd0);

        // counter saturation and clear during a stall
        exp_q.push_back(32'h40);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            checkOutput("cnt_sat", 32'(stall_cnt), (k < 7) ? 32'(k) : 32'd7);
        end
        cnt_clr = 1'b1;
        step();
        checkOutput("cnt_cleared", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b0;
        step();
        checkOutput("cnt_resume", 32'(stall_cnt), 32'd1);
        out_ready = 1'b1;
        step();
        step();
        checkOutput("cnt_drained", 32'(out_valid), 32'd0);
        checkOutput("cnt_after_drain", 32'(stall_cnt), 32'd1);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
